sync_frame_tx: RTL and testbench
================================

# sync_frame_tx

- Serial framing transmitter: the source-side counterpart to the team's 11011 non-overlapping Mealy detector.
- Accepts a parallel data word over a valid/ready handshake and emits one bit per clock, MSB first: the 5-bit sync word 11011, the data bits, an optional parity bit, then a guard gap of zeros.
- Drives the detector's serial input on-chip or from the bench, so every frame's sync word can be detected without overlap.

## Interface
- DATA_W, 8, payload bits per frame; legal range 1..16.
- GAP_LEN, 2, guard bits of 0 after each frame; legal range 0..15.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  source has a word to send.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  DATA_W  payload; sampled only on accept.
- tx_bit  output  1  serial bit, registered.
- tx_active  output  1  high while sync/data/parity bits are on tx_bit, registered.

## Operation
- States: IDLE, SYNC, DATA, PAR (only with parity), GAP.
- IDLE: in_ready=1, tx_bit=0, tx_active=0. Accept = in_valid && in_ready at a rising clk. On accept, in_data is latched into a shift register and the block enters SYNC.
- SYNC: 5 cycles, tx_bit = 1,1,0,1,1, then DATA.
- DATA: DATA_W cycles, tx_bit = latched word MSB first, then PAR or GAP.
- PAR: 1 cycle, tx_bit = even parity (XOR of all data bits), then GAP.
- GAP: GAP_LEN cycles, tx_bit=0, tx_active=0, then IDLE. GAP_LEN=0 goes directly to IDLE.
- in_ready = (state==IDLE) and not rst. It is 0 in every other state, and in_data changes there are ignored.
- Payload bits are not escaped. A 11011 pattern inside the data may be matched by a receiver; this is the source's responsibility.
- Down-counter width = clog2(max(DATA_W, GAP_LEN, 5)+1). It reloads on each state entry, and wrap-around never occurs.

## Timing
- Reset (async assert): state=IDLE, tx_bit=0, tx_active=0, shift register and counter cleared, in_ready=0 while rst is high.
- Reset mid-frame: outputs drop to 0 immediately and the frame is discarded. After release the block is in IDLE with in_ready=1 in the first cycle.
- Latency: the first sync bit appears on tx_bit in the cycle after the accept edge.
- Frame length F = 5 + DATA_W (+1 with parity). tx_active is high for exactly F consecutive cycles.
- Back-to-back throughput: one frame per F + GAP_LEN + 1 cycles, since the accept takes one IDLE cycle.
- in_valid held high continuously produces frames separated by GAP_LEN+1 zero bits.

## Configuration
- Macro: SYNC_FRAME_TX_PARITY_EN.
- Defined: the PAR state exists, one even-parity bit is sent after the data, and F = 6 + DATA_W.
- Undefined: the PAR state is compiled out, DATA goes directly to GAP, and F = 5 + DATA_W.

## Structure
- Shared package sync_frame_pkg holds:
  - SYNC_WORD = 5'b11011 and SYNC_LEN = 5, also used by the detector side;
  - the state enum.
- One sub-module: sync_frame_piso, a DATA_W-bit parallel-load, MSB-first shift register with load/shift enables and async active-high clear. The FSM and counter stay in the top module.

## Test plan
- Reset, DATA_W=8, GAP_LEN=2, no parity, accept 8'hA5 -> tx_bit = 1101110100101 followed by 0,0. tx_active high for 13 cycles. in_ready returns 1 on cycle 16 after accept.
- Parity build, accept 8'h01 -> parity bit 1 after the data. Accept 8'hA5 -> parity bit 0. tx_active high for 14 cycles.
- in_valid held high with words 8'hFF then 8'h00 -> two frames separated by exactly 3 zero bits. The second frame carries 00000000 after its sync word.
- in_data toggled while the block is busy -> transmitted bits equal the value latched at accept.
- Assert rst during the 3rd data bit -> tx_bit=0 and tx_active=0 without waiting for a clock edge. After release, in_ready=1 and a new 8'h3C frame is sent complete.
- Loopback into the 11011 detector with payload 8'h00 -> exactly one detection per frame, at the 5th sync bit.

Source files
------------

// File: rtl/sync_frame_pkg.sv
// Shared definitions for the 11011 sync framing transmitter and its matching detector.
// The sync word and its length are shared by both sides of the link.
package sync_frame_pkg;

   localparam logic [4:0] SYNC_WORD = 5'b11011;
   localparam int         SYNC_LEN  = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_DATA,
      ST_PAR,
      ST_GAP
   } state_t;

   function automatic logic sync_bit(input logic [2:0] idx);
      return SYNC_WORD[idx];
   endfunction

endpackage

// File: rtl/sync_frame_piso.sv
// Parallel-load, MSB-first shift register holding the payload of the frame in flight.
module sync_frame_piso #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] din,
   output logic         msb
);

   logic [W-1:0] sr_q;
   logic [W-1:0] sr_d;

   always_comb begin
      sr_d = sr_q;
      if (load) begin
         sr_d = din;
      end else if (shift) begin
         sr_d = sr_q << 1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign msb = sr_q[W-1];

endmodule

// File: rtl/sync_frame_tx.sv
// Serial framing transmitter: sync word 11011, payload MSB first, optional even parity, zero guard gap.
// Define SYNC_FRAME_TX_PARITY_EN to append the even-parity bit after the payload.
module sync_frame_tx
   import sync_frame_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int GAP_LEN = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              tx_bit,
   output logic              tx_active
);

   // Handshake: a word is taken on any rising edge where in_valid && in_ready;
   // in_ready is high only in IDLE and never while rst is asserted.

   localparam int MAX_DG = (DATA_W > GAP_LEN) ? DATA_W : GAP_LEN;
   localparam int MAX_N  = (MAX_DG > SYNC_LEN) ? MAX_DG : SYNC_LEN;
   localparam int CNT_W  = $clog2(MAX_N + 1);

   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tx_bit_q, tx_bit_d;
   logic             tx_active_q, tx_active_d;
   logic             accept;
   logic             load;
   logic             shift;
   logic             piso_msb;

`ifdef SYNC_FRAME_TX_PARITY_EN
   logic par_q, par_d;

   always_comb begin
      par_d = par_q;
      if (accept) begin
         par_d = ^in_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par_q <= 1'b0;
      end else begin
         par_q <= par_d;
      end
   end
`endif

   assign in_ready = (state_q == ST_IDLE) && !rst;
   assign accept   = in_valid && in_ready;

   // Outputs are registered: each branch computes the bit that goes on the
   // line during the state/count being entered, so cnt_q indexes what is next.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      tx_bit_d    = 1'b0;
      tx_active_d = 1'b0;
      load        = 1'b0;
      shift       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d     = ST_SYNC;
               cnt_d       = SYNC_LAST;
               tx_bit_d    = SYNC_WORD[SYNC_LEN-1];
               tx_active_d = 1'b1;
               load        = 1'b1;
            end
         end
         ST_SYNC: begin
            tx_active_d = 1'b1;
            if (cnt_q != '0) begin
               cnt_d    = cnt_q - CNT_ONE;
               tx_bit_d = sync_bit(cnt_q[2:0] - 3'd1);
            end else begin
               state_d  = ST_DATA;
               cnt_d    = DATA_LAST;
               tx_bit_d = piso_msb;
               shift    = 1'b1;
            end
         end
         ST_DATA: begin
            if (cnt_q != '0) begin
               cnt_d       = cnt_q - CNT_ONE;
               tx_bit_d    = piso_msb;
               tx_active_d = 1'b1;
               shift       = 1'b1;
            end else begin
`ifdef SYNC_FRAME_TX_PARITY_EN
               state_d     = ST_PAR;
               tx_bit_d    = par_q;
               tx_active_d = 1'b1;
`else
               if (GAP_LEN > 0) begin
                  state_d = ST_GAP;
                  cnt_d   = GAP_LAST;
               end else begin
                  state_d = ST_IDLE;
               end
`endif
            end
         end
`ifdef SYNC_FRAME_TX_PARITY_EN
         ST_PAR: begin
            if (GAP_LEN > 0) begin
               state_d = ST_GAP;
               cnt_d   = GAP_LAST;
            end else begin
               state_d = ST_IDLE;
            end
         end
`endif
         ST_GAP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_ONE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         tx_bit_q    <= 1'b0;
         tx_active_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tx_bit_q    <= tx_bit_d;
         tx_active_q <= tx_active_d;
      end
   end

   sync_frame_piso #(
      .W(DATA_W)
   ) u_piso (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .shift(shift),
      .din  (in_data),
      .msb  (piso_msb)
   );

   assign tx_bit    = tx_bit_q;
   assign tx_active = tx_active_q;

endmodule

// File: tb/tb_sync_frame_tx.sv
// Directed and randomized bench for sync_frame_tx with a frame-level reference model.
`timescale 1ns/1ps
module tb_sync_frame_tx;
   import sync_frame_pkg::*;

   localparam int DW = 8;
   localparam int GL = 2;
`ifdef SYNC_FRAME_TX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int F = SYNC_LEN + DW + PB;

   logic          clk      = 1'b0;
   logic          rst      = 1'b1;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data  = '0;
   logic          in_ready;
   logic          tx_bit;
   logic          tx_active;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   // expected line samples, {tx_active, tx_bit}
   logic [1:0] exp_q[$];

   logic [4:0] det_sr;
   int         det_fill;
   int         det_cnt;
   int         det_pos;

   always #5 clk = ~clk;

   sync_frame_tx #(
      .DATA_W (DW),
      .GAP_LEN(GL)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .tx_bit   (tx_bit),
      .tx_active(tx_active)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Reference frame: sync word, payload MSB first, even parity, zero gap.
   task automatic push_frame(input logic [DW-1:0] w);
      for (int i = SYNC_LEN - 1; i >= 0; i--) exp_q.push_back({1'b1, SYNC_WORD[i]});
      for (int i = DW - 1; i >= 0; i--) exp_q.push_back({1'b1, w[i]});
      if (PB == 1) exp_q.push_back({1'b1, ^w});
      for (int i = 0; i < GL; i++) exp_q.push_back(2'b00);
   endtask

   task automatic det_reset();
      det_sr   = '0;
      det_fill = 0;
      det_cnt  = 0;
      det_pos  = -1;
   endtask

   // Non-overlapping 11011 matcher fed with the observed line.
   task automatic det_feed(input logic b, input int idx);
      det_sr = {det_sr[3:0], b};
      det_fill++;
      if (det_fill >= 5 && det_sr == 5'b11011) begin
         det_cnt++;
         det_pos  = idx;
         det_fill = 0;
      end
   endtask

   task automatic check_stream(input string tag, input int drop_at, input bit scramble,
                               input bit busy);
      logic [1:0] e;
      int         idx;
      idx = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         @(negedge clk);
         check({tag, "_bit"}, tx_bit, e[0]);
         check({tag, "_active"}, tx_active, e[1]);
         if (busy) check({tag, "_ready_low"}, in_ready, 1'b0);
         det_feed(tx_bit, idx);
         if (scramble) in_data = DW'($urandom);
         if (idx == drop_at) in_valid = 1'b0;
         idx++;
      end
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("ready_timeout", in_ready, 1'b1);
   endtask

   task automatic run_frame(input logic [DW-1:0] w, input bit scramble);
      wait_ready();
      in_valid = 1'b1;
      in_data  = w;
      @(posedge clk);
      push_frame(w);
      det_reset();
      check_stream("frame", 0, scramble, 1'b1);
      @(negedge clk);
      check("ready_after_frame", in_ready, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1);
   end

   initial begin
      // reset values
      #1;
      check("rst_tx_bit", tx_bit, 1'b0);
      check("rst_tx_active", tx_active, 1'b0);
      check("rst_in_ready", in_ready, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post_rst_ready", in_ready, 1'b1);

      // directed payloads, including parity 1 and parity 0 cases
      run_frame(8'hA5, 1'b0);
      check("a5_det_cnt", det_cnt, 1);
      run_frame(8'h01, 1'b0);

      // in_valid held high: FF then 00, three zero bits between frames
      wait_ready();
      in_valid = 1'b1;
      in_data  = 8'hFF;
      @(posedge clk);
      #1 in_data = 8'h00;
      push_frame(8'hFF);
      exp_q.push_back(2'b00);
      push_frame(8'h00);
      det_reset();
      check_stream("b2b", F + GL + 1, 1'b0, 1'b0);
      check("b2b_det_cnt", det_cnt, 2);

      // randomized payloads with in_data scrambled while busy
      for (int k = 0; k < 6; k++) begin
         run_frame(DW'($urandom), 1'b1);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      // loopback: all-zero payload gives exactly one detection on the 5th sync bit
      run_frame(8'h00, 1'b0);
      check("loop_det_cnt", det_cnt, 1);
      check("loop_det_pos", det_pos, 4);

      // reset during the 3rd data bit
      wait_ready();
      in_valid = 1'b1;
      in_data  = 8'hE7;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (SYNC_LEN + 2) @(negedge clk);
      check("mid_data3_bit", tx_bit, 1'b1);
      check("mid_data3_active", tx_active, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_bit", tx_bit, 1'b0);
      check("mid_rst_active", tx_active, 1'b0);
      check("mid_rst_ready", in_ready, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_release_ready", in_ready, 1'b1);
      run_frame(8'h3C, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
